// File: rtl/dmem_responder_pkg.sv
// Shared pipeline types for the data-memory responder: access-size encoding,
// responder FSM states and the latency ceiling.
package dmem_responder_pkg;

  typedef enum logic [2:0] {
    MSize_zero   = 3'd0,
    MSize_8bits  = 3'd1,
    MSize_16bits = 3'd2,
    MSize_32bits = 3'd3,
    MSize_64bits = 3'd4
  } MemSizeType;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_MAX_LATENCY = 15;
  localparam int DMEM_CNT_W       = $clog2(DMEM_MAX_LATENCY + 1);

  // True when the size code is illegal or the low address bits break natural alignment.
  function automatic logic size_bad(input logic [2:0] size, input logic [2:0] lo);
    logic bad;
    case (size)
      MSize_8bits:  bad = 1'b0;
      MSize_16bits: bad = lo[0];
      MSize_32bits: bad = |lo[1:0];
      MSize_64bits: bad = |lo[2:0];
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// 64-bit word RAM: byte-strobed synchronous write, asynchronous read on one address.
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    strobe,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  // Update only the strobed byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (strobe[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request in IDLE, waits
// LATENCY cycles, then returns the addressed word (and commits any write) in RESP.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_wdata,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [DMEM_CNT_W-1:0] CNT_INIT =
    (LATENCY == 0) ? '0 : DMEM_CNT_W'(LATENCY - 1);

  dmem_state_t           state, state_n;
  logic [DMEM_CNT_W-1:0] cnt;
  logic [63:0]           lat_addr;
  logic [2:0]            lat_size;
  logic [7:0]            lat_strobe;
  logic [63:0]           lat_wdata;
  logic                  acc_err;
  logic                  wr_en;
  logic [63:0]           rd_word;

  // Error is a pure function of the latched request; evaluated when the response is due.
  assign acc_err = (lat_addr[63:3] >= 61'(DEPTH_WORDS)) || size_bad(lat_size, lat_addr[2:0]);

  // State register, latency counter and request capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_size   <= '0;
      lat_strobe <= '0;
      lat_wdata  <= '0;
    end else begin
      state <= state_n;
      if (resp_addr_ok) begin
        cnt        <= CNT_INIT;
        lat_addr   <= req_addr;
        lat_size   <= req_size;
        lat_strobe <= req_strobe;
        lat_wdata  <= req_wdata;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Next-state and response outputs; write commits on the RESP edge unless reset drops it.
  always_comb begin
    state_n      = state;
    resp_addr_ok = 1'b0;
    resp_data_ok = 1'b0;
    resp_err     = 1'b0;
    resp_rdata   = '0;
    wr_en        = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && reset) begin
          resp_addr_ok = 1'b1;
          state_n      = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) state_n = RESP;
      end
      RESP: begin
        resp_data_ok = 1'b1;
        resp_err     = acc_err;
        resp_rdata   = acc_err ? '0 : rd_word;
        wr_en        = !acc_err && (|lat_strobe) && reset;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  dmem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clk    (clk),
    .we     (wr_en),
    .addr   (lat_addr[AW+2:3]),
    .strobe (lat_strobe),
    .wdata  (lat_wdata),
    .rdata  (rd_word)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 main instance, LATENCY=0 for throughput.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_wdata;
  logic        resp_addr_ok, resp_data_ok, resp_err;
  logic [63:0] resp_rdata;

  logic        v0;
  logic        aok0, dok0, er0;
  logic [63:0] rd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_size(req_size), .req_strobe(req_strobe), .req_wdata(req_wdata),
    .resp_addr_ok(resp_addr_ok), .resp_data_ok(resp_data_ok),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_addr(64'h0),
    .req_size(3'(MSize_64bits)), .req_strobe(8'h00), .req_wdata(64'h0),
    .resp_addr_ok(aok0), .resp_data_ok(dok0),
    .resp_rdata(rd0), .resp_err(er0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Issue one request and hold it until data_ok; returns data_ok cycle (-1 on timeout).
  task automatic xact(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st,
                      input logic [63:0] wd, output logic [63:0] rd, output logic er,
                      output int lat, output logic ok0, output int stray);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_size = sz; req_strobe = st; req_wdata = wd;
    #1 ok0 = resp_addr_ok;
    lat = -1; rd = '0; er = 1'b0; stray = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (resp_addr_ok) stray++;
      if (resp_data_ok) begin
        lat = c; rd = resp_rdata; er = resp_err;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic [63:0] a, input logic [2:0] sz,
                     input logic [7:0] st, input logic [63:0] wd,
                     input bit ck_rd, input logic [63:0] exp_rd, input logic exp_er);
    logic [63:0] rd; logic er, ok0; int lat, stray;
    xact(a, sz, st, wd, rd, er, lat, ok0, stray);
    chk({tag, "_aok"}, 64'(ok0), 64'd1);
    chk({tag, "_lat"}, 64'(lat), 64'd3);
    chk({tag, "_stray_aok"}, 64'(stray), 64'd0);
    chk({tag, "_err"}, 64'(er), 64'(exp_er));
    if (ck_rd) chk({tag, "_rdata"}, rd, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int dcnt;
    reset = 1'b0; req_valid = 1'b1; req_addr = 64'h10; req_size = 3'(MSize_64bits);
    req_strobe = 8'h00; req_wdata = '0; v0 = 1'b0;

    // Reset held with a request pending: nothing is accepted.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_aok", 64'(resp_addr_ok), 64'd0);
    chk("rst_dok", 64'(resp_data_ok), 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_state", 64'(dut.state), 64'(IDLE));
    req_valid = 1'b0;
    reset = 1'b1;

    // Full-word write then read back.
    run("wr10", 64'h10, 3'(MSize_64bits), 8'hFF, 64'h1122334455667788, 1'b0, '0, 1'b0);
    run("rd10", 64'h10, 3'(MSize_64bits), 8'h00, '0, 1'b1, 64'h1122334455667788, 1'b0);

    // Single byte lane 3; write returns the pre-write word.
    run("wrb13", 64'h13, 3'(MSize_8bits), 8'h08, 64'h00000000AA000000, 1'b1, 64'h1122334455667788, 1'b0);
    run("rdb10", 64'h10, 3'(MSize_64bits), 8'h00, '0, 1'b1, 64'h11223344AA667788, 1'b0);

    // Alignment and size-code checks around word 0x20.
    run("wr20", 64'h20, 3'(MSize_64bits), 8'hFF, 64'hCAFEF00D12345678, 1'b0, '0, 1'b0);
    run("rd22_32", 64'h22, 3'(MSize_32bits), 8'h00, '0, 1'b1, 64'h0, 1'b1);
    run("wr22_32", 64'h22, 3'(MSize_32bits), 8'h3C, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0, 1'b1);
    run("rd21_16", 64'h21, 3'(MSize_16bits), 8'h00, '0, 1'b1, 64'h0, 1'b1);
    run("rd22_16", 64'h22, 3'(MSize_16bits), 8'h00, '0, 1'b1, 64'hCAFEF00D12345678, 1'b0);
    run("rd24_64", 64'h24, 3'(MSize_64bits), 8'h00, '0, 1'b1, 64'h0, 1'b1);
    run("rd27_8", 64'h27, 3'(MSize_8bits), 8'h00, '0, 1'b1, 64'hCAFEF00D12345678, 1'b0);
    run("sz_zero", 64'h20, 3'(MSize_zero), 8'h00, '0, 1'b1, 64'h0, 1'b1);
    run("sz_undef", 64'h20, 3'd7, 8'h00, '0, 1'b1, 64'h0, 1'b1);
    run("rd20", 64'h20, 3'(MSize_64bits), 8'h00, '0, 1'b1, 64'hCAFEF00D12345678, 1'b0);

    // Range edge: last word is legal, first word past the end errors and writes nothing.
    run("wr0", 64'h0, 3'(MSize_64bits), 8'hFF, 64'h0123456789ABCDEF, 1'b0, '0, 1'b0);
    run("wr1ff8", 64'h1FF8, 3'(MSize_64bits), 8'hFF, 64'h5555AAAA5555AAAA, 1'b0, '0, 1'b0);
    run("wr2000", 64'h2000, 3'(MSize_64bits), 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b1, 64'h0, 1'b1);
    run("rd0", 64'h0, 3'(MSize_64bits), 8'h00, '0, 1'b1, 64'h0123456789ABCDEF, 1'b0);
    run("rd1ff8", 64'h1FF8, 3'(MSize_64bits), 8'h00, '0, 1'b1, 64'h5555AAAA5555AAAA, 1'b0);

    // Reset one cycle after accepting a write drops it.
    run("wr18", 64'h18, 3'(MSize_64bits), 8'hFF, 64'h0F0F0F0F0F0F0F0F, 1'b0, '0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 64'h18; req_size = 3'(MSize_64bits);
    req_strobe = 8'hFF; req_wdata = 64'hA5A5A5A5A5A5A5A5;
    #1 chk("rw_aok", 64'(resp_addr_ok), 64'd1);
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("rw_state", 64'(dut.state), 64'(IDLE));
    chk("rw_dok", 64'(resp_data_ok), 64'd0);
    chk("rw_rdata", resp_rdata, 64'd0);
    chk("rw_err", 64'(resp_err), 64'd0);
    reset = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_data_ok) dcnt++;
    end
    chk("rw_no_dok", 64'(dcnt), 64'd0);
    run("rd18", 64'h18, 3'(MSize_64bits), 8'h00, '0, 1'b1, 64'h0F0F0F0F0F0F0F0F, 1'b0);

    // LATENCY=0 with req_valid held: alternating accept / respond.
    @(negedge clk);
    v0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("l0_aok%0d", k), 64'(aok0), 64'((k % 2) == 0));
      chk($sformatf("l0_dok%0d", k), 64'(dok0), 64'((k % 2) == 1));
    end
    v0 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 64-bit words in the backing array.
REQ-002 Parameter LATENCY, default 2, wait cycles between request acceptance and response, legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 req_valid  input  1  requester holds high from issue until it sees resp_data_ok.
REQ-006 req_addr  input  64  byte address.
REQ-007 req_size  input  3  access size, MemSizeType encoding (MSize_8bits..MSize_64bits).
REQ-008 req_strobe  input  8  byte-lane write enables; all-zero means read.
REQ-009 req_wdata  input  64  lane-aligned write data.
REQ-010 resp_addr_ok  output  1  request accepted this cycle.
REQ-011 resp_data_ok  output  1  single-cycle response pulse.
REQ-012 resp_rdata  output  64  full addressed 64-bit word, lane-aligned; the requester performs extract/extend.
REQ-013 resp_err  output  1  qualified by resp_data_ok; misaligned or out-of-range access.

Function
REQ-014 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-015 IDLE with req_valid=1: resp_addr_ok=1 combinationally that cycle; addr, size, strobe and wdata latched; next state WAIT with counter=LATENCY-1, or RESP if LATENCY=0.
REQ-016 WAIT: counter decrements each cycle; at 0, next state RESP; req inputs ignored.
REQ-017 RESP: resp_data_ok=1 for exactly one cycle; next state IDLE unconditionally.
REQ-018 Acceptance-to-data_ok latency is exactly LATENCY+1 cycles.
REQ-019 Back-to-back: a req_valid seen in IDLE the cycle after RESP is a new request; throughput is at most one request per LATENCY+2 cycles.
REQ-020 Word index = addr[63:3]; index >= DEPTH_WORDS sets resp_err.
REQ-021 Misalignment (16-bit with addr[0]!=0, 32-bit with addr[1:0]!=0, 64-bit with addr[2:0]!=0) sets resp_err; MSize_zero or an undefined size also sets resp_err.
REQ-022 resp_err=1: no array write; resp_rdata=0.
REQ-023 Write (strobe nonzero, no error): only strobed byte lanes are updated, at the RESP-cycle edge; resp_rdata returns the pre-write word.
REQ-024 Read: resp_rdata is the word at the latched index, sampled in RESP.
REQ-025 Outside RESP, resp_data_ok=0, resp_err=0 and resp_rdata=0; outside IDLE, resp_addr_ok=0.
REQ-026 If req_valid drops before data_ok, the transaction still completes; no cancel.

Reset
REQ-027 reset=0 at any edge forces IDLE, counter 0 and all outputs 0 in the following cycle, including mid-WAIT or mid-RESP; a pending write is dropped.
REQ-028 Array contents are not cleared by reset.
REQ-029 reset=0 while req_valid=1 does not produce addr_ok in that cycle.

Structure
REQ-030 The dmem_state_t enum (IDLE/WAIT/RESP) and a DMEM_MAX_LATENCY constant (15) are placed in the shared pipes package; MemSizeType is reused from there.
REQ-031 The storage is a sub-module dmem_array: a 64-bit word RAM with an 8-bit byte-write strobe and a synchronous write / asynchronous read port.
REQ-032 All FSM, latency-counter and error-check logic lives in dmem_responder.

Verification
REQ-033 Write/read: LATENCY=2, write addr 0x10, size 64, strobe 0xFF, wdata 0x1122334455667788 -> addr_ok at cycle 0, data_ok at cycle 3, err=0; read of 0x10 -> rdata 0x1122334455667788.
REQ-034 Byte strobe: after REQ-033, write addr 0x13, size 8, strobe 0x08, wdata 0x00000000AA000000 -> read of 0x10 returns 0x11223344AA667788.
REQ-035 Misaligned: read addr 0x22, size 32 -> data_ok with err=1, rdata 0; a subsequent read of 0x20 returns the unmodified word.
REQ-036 Out of range: DEPTH_WORDS=1024, write addr 0x2000 -> err=1; no array word changes.
REQ-037 Reset mid-WAIT: accept a write to 0x18, assert reset=0 one cycle later -> no data_ok; the word at 0x18 is unchanged; outputs are 0; the FSM is in IDLE.
REQ-038 LATENCY=0 with req_valid held high -> addr_ok every second cycle, data_ok on the cycle after each addr_ok.
